// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage: default widths, reset PC,
// timeout budget and the two-state FSM encoding.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned INSTR_W_DEF = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam int unsigned TIMEOUT_DEF = 15;

  // Width of the WAIT-cycle timer; it saturates rather than wrapping.
  localparam int unsigned TIMER_W = 8;

  // Fetch FSM encoding, kept bit-compatible with the legacy control unit.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: address/request from the fetch unit,
// data/acknowledge from memory.
interface instr_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
);

  logic [ADDR_W-1:0]  mem_adr;
  logic               mem_req;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_ack;

  modport master (
    output mem_adr,
    output mem_req,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_adr,
    input  mem_req,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/fetch_timer.sv
// 8-bit saturating WAIT-cycle counter; expired flags the last cycle a fetch
// may wait before the fetch unit gives up.
module fetch_timer
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns PC, old-PC and instruction registers, drives
// the memory address mux, and runs the req/ack read handshake with stall,
// misalignment and timeout detection. RESET_PC must be even.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = ADDR_W_DEF,
  parameter int unsigned        INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned        TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ir_wr,
  input  logic                pc_write,
  input  logic                adr_src,
  input  logic [ADDR_W-1:0]   pc_next,
  input  logic [ADDR_W-1:0]   data_adr,
  instr_fetch_unit_if.master  mem,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   old_pc,
  output logic [INSTR_W-1:0]  instruction,
  output logic                stall,
  output logic                fetch_err
);

  logic [0:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  old_pc_q, old_pc_d;
  logic [ADDR_W-1:0]  fetch_adr_q, fetch_adr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               err_q, err_d;
  logic               accept;
  logic               timer_en;
  logic               timer_expired;

  // A fetch is launched only from IDLE with an even PC.
  assign accept   = (state_q == IDLE) && ir_wr && !pc_q[0];
  assign timer_en = (state_q == WAIT);

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Next-state logic for the FSM and all architectural registers.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    old_pc_d    = old_pc_q;
    fetch_adr_d = fetch_adr_q;
    instr_d     = instr_q;
    err_d       = err_q;

    // PC load is independent of the fetch; fetch_adr keeps the in-flight address.
    if (pc_write) begin
      pc_d = pc_next;
    end

    if (state_q == IDLE) begin
      if (ir_wr) begin
        if (pc_q[0]) begin
          err_d = 1'b1;
        end else begin
          fetch_adr_d = pc_q;
          err_d       = 1'b0;
          state_d     = WAIT;
        end
      end
    end else begin
      // Ack takes priority over an expiring timer in the same cycle.
      if (mem.mem_ack) begin
        instr_d  = mem.mem_rdata;
        old_pc_d = fetch_adr_q;
        state_d  = IDLE;
      end else if (timer_expired) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      old_pc_q    <= '0;
      fetch_adr_q <= '0;
      instr_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      old_pc_q    <= old_pc_d;
      fetch_adr_q <= fetch_adr_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_req = (state_q == WAIT);
  assign mem.mem_adr = (state_q == WAIT) ? fetch_adr_q
                     : (adr_src ? data_adr : pc_q);

  assign stall       = (state_q == WAIT) || accept;
  assign pc          = pc_q;
  assign old_pc      = old_pc_q;
  assign instruction = instr_q;
  assign fetch_err   = err_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the 16-bit multicycle RISC-V-style core, sitting directly upstream of the control unit. It owns the program counter, the old-PC register and the instruction register, and drives the memory address mux selected by `adr_src`. On `ir_wr` it runs a req/ack read handshake with instruction memory, asserting `stall` so the control FSM holds in FETCH until the instruction is latched. It also detects misaligned PCs and bus timeouts.

## Interface
- `ADDR_W`, 16: PC and memory address width.
- `INSTR_W`, 16: instruction width.
- `RESET_PC`, 16'h0000: PC value after reset; must be even.
- `TIMEOUT`, 15: maximum WAIT cycles without `mem_ack` before a fetch error is raised; range 1..255.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ir_wr`  in  1  fetch request from the control unit; accepted only in IDLE.
- `pc_write`  in  1  load `pc` from `pc_next` at the next edge.
- `adr_src`  in  1  IDLE address select: 0 = `pc`, 1 = `data_adr`.
- `pc_next`  in  ADDR_W  new PC value (ALU result or branch target).
- `data_adr`  in  ADDR_W  load/store address from the datapath.
- `mem_rdata`  in  INSTR_W  memory read data.
- `mem_ack`  in  1  memory read complete; `mem_rdata` is valid in the same cycle.
- `mem_adr`  out  ADDR_W  memory address.
- `mem_req`  out  1  instruction read request (registered).
- `pc`  out  ADDR_W  current PC.
- `old_pc`  out  ADDR_W  address of the instruction held in `instruction`.
- `instruction`  out  INSTR_W  instruction register; feeds the control unit.
- `stall`  out  1  control FSM must hold its state.
- `fetch_err`  out  1  sticky error flag (misalign or timeout).

## Operation
- Two-state FSM:
  - **IDLE**: `mem_req` = 0.
  - **WAIT**: `mem_req` = 1.
- **IDLE, `ir_wr`=1, `pc[0]`=0:**
  - `fetch_adr` <= `pc`; timer <= 0; `fetch_err` <= 0.
  - Next state WAIT.
- **IDLE, `ir_wr`=1, `pc[0]`=1:**
  - No request is issued; `fetch_err` <= 1.
  - State stays IDLE; `instruction` is unchanged.
- **WAIT, `mem_ack`=1:**
  - `instruction` <= `mem_rdata`; `old_pc` <= `fetch_adr`.
  - Next state IDLE.
- **WAIT, no ack:**
  - Timer increments each cycle.
  - When the timer reaches TIMEOUT-1 with no ack: `fetch_err` <= 1, next state IDLE, `instruction` and `old_pc` unchanged.
- **`ir_wr` during WAIT**: ignored; it does not queue a second fetch.
- **`pc_write`**: `pc` <= `pc_next` in any state. `fetch_adr` is not affected, so an in-flight fetch completes at the original address.
- **`mem_adr`**:
  - WAIT: `fetch_adr`.
  - IDLE: `adr_src` ? `data_adr` : `pc`.
- **`stall`** (combinational) = (state==WAIT) | (state==IDLE & `ir_wr` & ~`pc[0]`).
- **Simultaneous events:**
  - `mem_ack` in the timeout cycle: the ack wins and no error is raised.
  - `pc_write` in the ack cycle: both updates take effect.
- **Arithmetic**: the timer is 8 bits and saturates. The unit performs no PC arithmetic; PC+2 comes via `pc_next`.

## Timing
- **Reset values**, applied asynchronously on `rst`=1 (including mid-WAIT):
  - state IDLE, `mem_req` 0, `pc` RESET_PC.
  - `old_pc` 0, `instruction` 0, `fetch_err` 0, timer 0.
- **Minimum fetch latency:**
  - `ir_wr` in cycle 0; `mem_req` high in cycle 1.
  - `mem_ack` in cycle 1; `instruction` valid in cycle 2.
  - `stall` is high in cycles 0–1.
- **Wait states**: each cycle of `mem_ack` delay adds one cycle to `stall` and to `mem_req`.
- **`mem_req`** drops in the cycle after the ack edge. Memory must not assert `mem_ack` while `mem_req` = 0; such an ack is ignored.
- **`pc_write`** takes effect at the next rising edge (`pc` visible one cycle later).

## Structure
- Shared package `fetch_pkg` holds:
  - FSM state encoding (IDLE=1'b0, WAIT=1'b1).
  - Default ADDR_W, INSTR_W, RESET_PC and TIMEOUT constants.
- Core opcode/state defines stay in their own existing header.
- Optional sub-module `fetch_timer`: 8-bit saturating counter with clear/enable and a `expired` output (timer == TIMEOUT-1). Everything else stays flat.

## Test plan
- **Reset**: reset, then `ir_wr` pulse with `mem_ack` returned in the first request cycle, `mem_rdata`=16'hA5C3 → `instruction`=16'hA5C3 and `old_pc`=0 in cycle 2; `stall` high for exactly 2 cycles.
- **Wait states**: ack delayed 3 cycles, `pc`=16'h0010 → `mem_adr`=16'h0010 held throughout; `mem_req` high for 4 cycles; `stall` high for 5 cycles.
- **PC write mid-fetch**: `pc_write` with `pc_next`=16'h0012 in cycle 1 of WAIT → `pc`=16'h0012, `mem_adr` still 16'h0010, and `old_pc`=16'h0010 after the ack.
- **Timeout**: TIMEOUT=4 with no ack → `fetch_err`=1 after 4 WAIT cycles, `mem_req` then low, `instruction` unchanged. A later good fetch clears `fetch_err`.
- **Misalign and ack-on-timeout**: `pc_write` with `pc_next`=16'h0003, then `ir_wr` → `fetch_err`=1, `mem_req` never rises. Separately, `mem_ack` arriving exactly in the timeout cycle → instruction latched, `fetch_err`=0.
- **Reset mid-fetch and data path**: `rst` asserted mid-WAIT → `mem_req` and `stall` drop immediately, `pc`=RESET_PC. In IDLE with `adr_src`=1 and `data_adr`=16'h0F00 → `mem_adr`=16'h0F00.
